// File: rtl/funct_generator_wave_gen.sv
// Waveform sample generator (sawtooth/triangle/square/constant) with a valid/ready output stream.
// Optional inter-sample gap enabled by FG_WAVE_PRESCALE_EN.
module funct_generator_wave_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            wave_sel,
   input  logic [DATA_WIDTH-1:0] step,
`ifdef FG_WAVE_PRESCALE_EN
   input  logic [7:0]            prescale,
`endif
   input  logic                  sample_ready,
   output logic [DATA_WIDTH-1:0] sample_data,
   output logic                  sample_valid,
   output logic                  reg_clr,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  sample_count,
   output logic [1:0]            state_dbg
);

   // Stream handshake: a sample transfers on any rising edge where sample_valid and
   // sample_ready are both high; sample_data is stable while valid is high without ready.

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t                state, state_n;
   logic [1:0]            wave_q, wave_n;
   logic [DATA_WIDTH-1:0] step_q, step_n;
   logic [DATA_WIDTH-1:0] phase, phase_n, nxt_phase;
   logic                  dir, dir_n, nxt_dir;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  valid_n, clr_n;
   logic [CNT_WIDTH-1:0]  count_n;
   logic [DATA_WIDTH:0]   sum;
   logic                  xfer;
`ifdef FG_WAVE_PRESCALE_EN
   logic [7:0]            pre_q, pre_n, gap_cnt, gap_n;
`endif

   function automatic logic [DATA_WIDTH-1:0] wave_map(input logic [1:0] w,
                                                      input logic [DATA_WIDTH-1:0] p,
                                                      input logic [DATA_WIDTH-1:0] s);
      case (w)
         2'd2:    wave_map = p[DATA_WIDTH-1] ? '0 : '1;
         2'd3:    wave_map = s;
         default: wave_map = p;
      endcase
   endfunction

   assign xfer      = sample_valid & sample_ready;
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   // dir: 0 = counting up, 1 = counting down (triangle only)
   always_comb begin
      sum       = {1'b0, phase} + {1'b0, step_q};
      nxt_phase = sum[DATA_WIDTH-1:0];
      nxt_dir   = dir;
      if (wave_q == 2'd1) begin
         if (!dir) begin
            if (sum[DATA_WIDTH]) begin
               nxt_phase = '1;
               nxt_dir   = 1'b1;
            end
         end else if (phase < step_q) begin
            nxt_phase = '0;
            nxt_dir   = 1'b0;
         end else begin
            nxt_phase = phase - step_q;
         end
      end
   end

   always_comb begin
      state_n = state;
      wave_n  = wave_q;
      step_n  = step_q;
      phase_n = phase;
      dir_n   = dir;
      data_n  = sample_data;
      valid_n = sample_valid;
      clr_n   = 1'b0;
      count_n = sample_count;
`ifdef FG_WAVE_PRESCALE_EN
      pre_n   = pre_q;
      gap_n   = gap_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (start && !stop) begin
               state_n = S_RUN;
               wave_n  = wave_sel;
               step_n  = step;
               phase_n = '0;
               dir_n   = 1'b0;
               count_n = '0;
               clr_n   = 1'b1;
               valid_n = 1'b1;
               data_n  = wave_map(wave_sel, '0, step);
`ifdef FG_WAVE_PRESCALE_EN
               pre_n   = prescale;
               gap_n   = 8'd0;
`endif
            end
         end
         S_RUN: begin
`ifdef FG_WAVE_PRESCALE_EN
            if (!sample_valid) begin
               // Gap between samples: phase already advanced, sample appears at gap end
               if (stop) begin
                  state_n = S_IDLE;
                  gap_n   = 8'd0;
               end else if (gap_cnt <= 8'd1) begin
                  gap_n   = 8'd0;
                  valid_n = 1'b1;
                  data_n  = wave_map(wave_q, phase, step_q);
               end else begin
                  gap_n   = gap_cnt - 8'd1;
               end
            end else
`endif
            if (xfer) begin
               count_n = sample_count + 1'b1;
               phase_n = nxt_phase;
               dir_n   = nxt_dir;
               if (stop) begin
                  state_n = S_IDLE;
                  valid_n = 1'b0;
               end else begin
`ifdef FG_WAVE_PRESCALE_EN
                  if (pre_q != 8'd0) begin
                     valid_n = 1'b0;
                     gap_n   = pre_q;
                  end else
`endif
                  data_n = wave_map(wave_q, nxt_phase, step_q);
               end
            end else if (stop) begin
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               count_n = sample_count + 1'b1;
               state_n = S_IDLE;
               valid_n = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         wave_q       <= 2'd0;
         step_q       <= '0;
         phase        <= '0;
         dir          <= 1'b0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         reg_clr      <= 1'b0;
         sample_count <= '0;
`ifdef FG_WAVE_PRESCALE_EN
         pre_q        <= 8'd0;
         gap_cnt      <= 8'd0;
`endif
      end else begin
         state        <= state_n;
         wave_q       <= wave_n;
         step_q       <= step_n;
         phase        <= phase_n;
         dir          <= dir_n;
         sample_data  <= data_n;
         sample_valid <= valid_n;
         reg_clr      <= clr_n;
         sample_count <= count_n;
`ifdef FG_WAVE_PRESCALE_EN
         pre_q        <= pre_n;
         gap_cnt      <= gap_n;
`endif
      end
   end

endmodule

// File: tb/tb_funct_generator_wave_gen.sv
// Self-checking bench for funct_generator_wave_gen: waveform tables plus handshake/stop/reset sequences.
module tb_funct_generator_wave_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, sample_ready;
   logic [1:0]  wave_sel;
   logic [7:0]  step;
   logic [7:0]  sample_data;
   logic        sample_valid, reg_clr, busy;
   logic [15:0] sample_count;
   logic [1:0]  state_dbg;
`ifdef FG_WAVE_PRESCALE_EN
   logic [7:0]  prescale;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]        wave;
      logic [7:0]        step;
      int                n;
      logic [0:7][7:0]   exp;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   funct_generator_wave_gen dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .wave_sel     (wave_sel),
      .step         (step),
`ifdef FG_WAVE_PRESCALE_EN
      .prescale     (prescale),
`endif
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .reg_clr      (reg_clr),
      .busy         (busy),
      .sample_count (sample_count),
      .state_dbg    (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string name);
      chk({name, ".data"},  32'(sample_data), 32'd0);
      chk({name, ".valid"}, 32'(sample_valid), 32'd0);
      chk({name, ".clr"},   32'(reg_clr), 32'd0);
      chk({name, ".busy"},  32'(busy), 32'd0);
      chk({name, ".count"}, 32'(sample_count), 32'd0);
   endtask

   task automatic run_vec(input int v);
      @(negedge clk);
      wave_sel     = vecs[v].wave;
      step         = vecs[v].step;
      sample_ready = 1'b1;
      start        = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("v%0d.s%0d.data", v, i), 32'(sample_data), 32'(vecs[v].exp[i]));
         chk($sformatf("v%0d.s%0d.valid", v, i), 32'(sample_valid), 32'd1);
         chk($sformatf("v%0d.s%0d.count", v, i), 32'(sample_count), 32'(i));
         chk($sformatf("v%0d.s%0d.clr", v, i), 32'(reg_clr), (i == 0) ? 32'd1 : 32'd0);
         if (i == vecs[v].n - 1) stop = 1'b1;
      end
      @(negedge clk);
      stop = 1'b0;
      chk($sformatf("v%0d.end.valid", v), 32'(sample_valid), 32'd0);
      chk($sformatf("v%0d.end.busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d.end.count", v), 32'(sample_count), 32'(vecs[v].n));
      chk($sformatf("v%0d.end.data", v), 32'(sample_data), 32'(vecs[v].exp[vecs[v].n-1]));
   endtask

   initial begin
      vecs[0] = '{2'd0, 8'd64,  6, {8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64, 8'd0, 8'd0}};
      vecs[1] = '{2'd1, 8'd100, 8, {8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100}};
      vecs[2] = '{2'd2, 8'd64,  6, {8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0}};
      vecs[3] = '{2'd3, 8'd77,  4, {8'd77, 8'd77, 8'd77, 8'd77, 8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[4] = '{2'd0, 8'd0,   3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
      vecs[5] = '{2'd1, 8'd200, 5, {8'd0, 8'd200, 8'd255, 8'd55, 8'd0, 8'd0, 8'd0, 8'd0}};

      rst = 1'b0; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
      wave_sel = 2'd0; step = 8'd0;
`ifdef FG_WAVE_PRESCALE_EN
      prescale = 8'd0;
`endif
      repeat (2) @(negedge clk);
      chk_idle_zero("reset");
      chk("reset.state", 32'(state_dbg), 32'd0);
      rst = 1'b1;

      for (int v = 0; v < 6; v++) run_vec(v);

      // Backpressure then stop while ready is low
      @(negedge clk);
      wave_sel = 2'd0; step = 8'd10; sample_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("bp.s0.data", 32'(sample_data), 32'd0);
      @(negedge clk);
      chk("bp.s1.data", 32'(sample_data), 32'd10);
      sample_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bp.hold%0d.data", i), 32'(sample_data), 32'd10);
         chk($sformatf("bp.hold%0d.valid", i), 32'(sample_valid), 32'd1);
         chk($sformatf("bp.hold%0d.count", i), 32'(sample_count), 32'd1);
      end
      sample_ready = 1'b1;
      @(negedge clk);
      chk("bp.s2.data", 32'(sample_data), 32'd20);
      chk("bp.s2.count", 32'(sample_count), 32'd2);
      sample_ready = 1'b0; stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("drain%0d.state", i), 32'(state_dbg), 32'd2);
         chk($sformatf("drain%0d.valid", i), 32'(sample_valid), 32'd1);
         chk($sformatf("drain%0d.busy", i), 32'(busy), 32'd1);
         chk($sformatf("drain%0d.data", i), 32'(sample_data), 32'd20);
         chk($sformatf("drain%0d.count", i), 32'(sample_count), 32'd2);
         if (i == 1) sample_ready = 1'b1;
         @(negedge clk);
      end
      chk("drain.end.valid", 32'(sample_valid), 32'd0);
      chk("drain.end.busy", 32'(busy), 32'd0);
      chk("drain.end.count", 32'(sample_count), 32'd3);
      chk("drain.end.data", 32'(sample_data), 32'd20);

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("ss.busy", 32'(busy), 32'd0);
      chk("ss.valid", 32'(sample_valid), 32'd0);
      chk("ss.count", 32'(sample_count), 32'd3);

      // Asynchronous reset in the middle of a run
      wave_sel = 2'd0; step = 8'd10; sample_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid.busy", 32'(busy), 32'd1);
      chk("mid.data", 32'(sample_data), 32'd20);
      #2 rst = 1'b0;
      #1 chk_idle_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;

`ifdef FG_WAVE_PRESCALE_EN
      @(negedge clk);
      prescale = 8'd2; wave_sel = 2'd0; step = 8'd64; sample_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("pre.c%0d.valid", c), 32'(sample_valid), (c % 3 == 0) ? 32'd1 : 32'd0);
         if (c % 3 == 0)
            chk($sformatf("pre.c%0d.data", c), 32'(sample_data), 32'(vecs[0].exp[c/3]));
         if (c == 15) stop = 1'b1;
      end
      @(negedge clk);
      stop = 1'b0;
      chk("pre.end.busy", 32'(busy), 32'd0);
      chk("pre.end.count", 32'(sample_count), 32'd6);
      prescale = 8'd0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
